// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port bit-masked SRAM macro.
// Issues one macro operation per cycle and records the first failing address and element.
module sram_march_bist #(
  parameter int NumWords  = 256,
  parameter int DataWidth = 64,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  output logic                 bist_en_o,
  output logic [AddrWidth-1:0] bist_addr_o,
  output logic [DataWidth-1:0] bist_din_o,
  output logic [DataWidth-1:0] bist_bm_o,
  output logic                 bist_men_o,
  output logic                 bist_wen_o,
  output logic                 bist_ren_o,
  input  logic [DataWidth-1:0] bist_dout_i
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StCheck = 2'd2} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

  // Data word for an operation: written pattern for writes, expected word for reads.
  function automatic logic [DataWidth-1:0] march_pat(input logic [2:0] elem, input logic is_wr);
    logic ones;
    if (is_wr) begin
      ones = (elem == 3'd1) || (elem == 3'd3);
    end else begin
      ones = (elem == 3'd2) || (elem == 3'd4);
    end
    return ones ? {DataWidth{1'b1}} : {DataWidth{1'b0}};
  endfunction

  state_e                 state_q, state_d;
  logic [2:0]             elem_q, elem_d, fail_elem_q, fail_elem_d, cmp_elem_q, cmp_elem_d;
  logic [AddrWidth-1:0]   addr_q, addr_d, fail_addr_q, fail_addr_d, cmp_addr_q, cmp_addr_d;
  logic [DataWidth-1:0]   din_q, din_d, cmp_exp_q, cmp_exp_d;
  logic                   en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic                   busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic                   cmp_valid_q, cmp_valid_d;
  logic [2:0]             nx_elem;
  logic [AddrWidth-1:0]   nx_addr;
  logic                   nx_wr, nx_fin;

  // Next march operation following the one currently driven on the macro port.
  always_comb begin
    nx_elem = elem_q;
    nx_addr = addr_q;
    nx_wr   = wen_q;
    nx_fin  = 1'b0;
    case (elem_q)
      3'd0: begin
        if (addr_q == LastAddr) begin
          nx_elem = 3'd1;
          nx_addr = '0;
          nx_wr   = 1'b0;
        end else begin
          nx_addr = addr_q + AddrOne;
        end
      end
      3'd1, 3'd2: begin
        if (!wen_q) begin
          nx_wr = 1'b1;
        end else if (addr_q == LastAddr) begin
          nx_elem = elem_q + 3'd1;
          nx_wr   = 1'b0;
          nx_addr = (elem_q == 3'd1) ? '0 : LastAddr;
        end else begin
          nx_wr   = 1'b0;
          nx_addr = addr_q + AddrOne;
        end
      end
      3'd3, 3'd4: begin
        if (!wen_q) begin
          nx_wr = 1'b1;
        end else if (addr_q == '0) begin
          nx_elem = elem_q + 3'd1;
          nx_wr   = 1'b0;
          nx_addr = (elem_q == 3'd3) ? LastAddr : '0;
        end else begin
          nx_wr   = 1'b0;
          nx_addr = addr_q - AddrOne;
        end
      end
      3'd5: begin
        if (addr_q == LastAddr) begin
          nx_fin = 1'b1;
        end else begin
          nx_addr = addr_q + AddrOne;
        end
      end
      default: nx_fin = 1'b1;
    endcase
  end

  // FSM next state, registered macro controls and read-data compare.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    din_d       = din_q;
    en_d        = en_q;
    men_d       = men_q;
    wen_d       = wen_q;
    ren_d       = ren_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    cmp_valid_d = ren_q;
    cmp_exp_d   = din_q;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;

    // Only the first mismatch since start is recorded.
    if (cmp_valid_q && (bist_dout_i != cmp_exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end else begin
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
      end
    end else begin
      fail_d = fail_q;
    end

    case (state_q)
      StIdle: begin
        en_d   = 1'b0;
        men_d  = 1'b0;
        wen_d  = 1'b0;
        ren_d  = 1'b0;
        addr_d = '0;
        din_d  = '0;
        elem_d = 3'd0;
        busy_d = 1'b0;
        if (start_i) begin
          state_d     = StRun;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          en_d        = 1'b1;
          men_d       = 1'b1;
          wen_d       = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        en_d = 1'b1;
        if (nx_fin) begin
          state_d = StCheck;
          men_d   = 1'b0;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          addr_d  = '0;
          din_d   = '0;
        end else begin
          state_d = StRun;
          men_d   = 1'b1;
          wen_d   = nx_wr;
          ren_d   = !nx_wr;
          elem_d  = nx_elem;
          addr_d  = nx_addr;
          din_d   = march_pat(nx_elem, nx_wr);
        end
      end
      StCheck: begin
        state_d = StIdle;
        en_d    = 1'b0;
        men_d   = 1'b0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        men_d   = 1'b0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, macro-port and compare-pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      din_q       <= '0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign bist_en_o   = en_q;
  assign bist_addr_o = addr_q;
  assign bist_din_o  = din_q;
  assign bist_bm_o   = {DataWidth{1'b1}};
  assign bist_men_o  = men_q;
  assign bist_wen_o  = wen_q;
  assign bist_ren_o  = ren_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench: a behavioural March C- model predicts the op stream and the
// pass/fail result for injected macro faults; monitors compare against the DUTs.
module tb_sram_march_bist;
  localparam int DW = 64;
  localparam int N0 = 256;
  localparam int A0 = 8;
  localparam int N1 = 64;
  localparam int A1 = 6;

  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, start64 = 1'b0;
  logic busy, done, fail, en, men, wen, ren;
  logic [A0-1:0] fail_addr, addr;
  logic [2:0] fail_elem;
  logic [DW-1:0] din, bm, dout;
  logic busy64, done64, fail64, en64, men64, wen64, ren64;
  logic [A1-1:0] fail_addr64, addr64;
  logic [2:0] fail_elem64;
  logic [DW-1:0] din64, bm64, dout64;

  always #5 clk = ~clk;

  sram_march_bist #(.NumWords(N0), .DataWidth(DW)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy), .done_o(done),
    .fail_o(fail), .fail_addr_o(fail_addr), .fail_elem_o(fail_elem), .bist_en_o(en),
    .bist_addr_o(addr), .bist_din_o(din), .bist_bm_o(bm), .bist_men_o(men),
    .bist_wen_o(wen), .bist_ren_o(ren), .bist_dout_i(dout));

  sram_march_bist #(.NumWords(N1), .DataWidth(DW)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start64), .busy_o(busy64), .done_o(done64),
    .fail_o(fail64), .fail_addr_o(fail_addr64), .fail_elem_o(fail_elem64), .bist_en_o(en64),
    .bist_addr_o(addr64), .bist_din_o(din64), .bist_bm_o(bm64), .bist_men_o(men64),
    .bist_wen_o(wen64), .bist_ren_o(ren64), .bist_dout_i(dout64));

  typedef struct packed {logic wr; logic [9:0] addr; logic [DW-1:0] data;} op_t;
  typedef struct packed {logic fail; logic [9:0] addr; logic [2:0] elem; int busy; int nw; int nr;} res_t;

  op_t  op_q[$], op_q64[$];
  res_t res_q[$], res_q64[$];
  int errors = 0, checks = 0;

  // Fault injected into the 256-word macro: a stuck bit and/or a dropped all-ones write.
  bit st_en = 1'b0, st_val = 1'b0, dr_en = 1'b0;
  int st_addr = 0, st_bit = 0, dr_addr = 0;

  logic [DW-1:0] mem0 [N0];
  logic [DW-1:0] mem1 [N1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] faulty_read(input int a);
    logic [DW-1:0] v;
    v = mem0[a];
    if (st_en && a == st_addr) v[st_bit] = st_val;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < N0; i++) mem0[i] <= {$urandom, $urandom};
      dout <= '0;
    end else if (men) begin
      if (wen && !(dr_en && int'(addr) == dr_addr && din == '1))
        mem0[addr] <= (mem0[addr] & ~bm) | (din & bm);
      if (ren) dout <= faulty_read(int'(addr));
    end
  end

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < N1; i++) mem1[i] <= {$urandom, $urandom};
      dout64 <= '0;
    end else if (men64) begin
      if (wen64) mem1[addr64] <= (mem1[addr64] & ~bm64) | (din64 & bm64);
      if (ren64) dout64 <= mem1[addr64];
    end
  end

  // Reference model: March C- run on a plain array with the same fault definition.
  logic [DW-1:0] mm [1024];
  bit mf;
  int mfa, mfe, mw, mr;

  task automatic m_op(input bit sel64, input bit wr, input int a, input bit one, input int e);
    op_t o;
    logic [DW-1:0] d, v;
    d = one ? '1 : '0;
    o.wr = wr; o.addr = 10'(a); o.data = d;
    if (sel64) op_q64.push_back(o); else op_q.push_back(o);
    if (wr) begin
      mw++;
      if (!(!sel64 && dr_en && a == dr_addr && one)) mm[a] = d;
    end else begin
      mr++;
      v = mm[a];
      if (!sel64 && st_en && a == st_addr) v[st_bit] = st_val;
      if (v != d && !mf) begin mf = 1'b1; mfa = a; mfe = e; end
    end
  endtask

  task automatic ref_run(input int n, input bit sel64);
    res_t r;
    int a;
    mf = 1'b0; mfa = 0; mfe = 0; mw = 0; mr = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (e == 3 || e == 4) ? n - 1 - i : i;
        if (e == 0) m_op(sel64, 1'b1, a, 1'b0, e);
        else if (e == 5) m_op(sel64, 1'b0, a, 1'b0, e);
        else begin
          m_op(sel64, 1'b0, a, (e == 2 || e == 4), e);
          m_op(sel64, 1'b1, a, (e == 1 || e == 3), e);
        end
      end
    end
    r.fail = mf; r.addr = 10'(mfa); r.elem = 3'(mfe);
    r.busy = 10 * n + 1; r.nw = mw; r.nr = mr;
    if (sel64) res_q64.push_back(r); else res_q.push_back(r);
  endtask

  // Monitor for the 256-word instance.
  int bcnt = 0, wcnt = 0, rcnt = 0;
  logic dprev = 1'b0;
  initial forever begin
    op_t o;
    res_t r;
    @(negedge clk);
    if (!rst_ni) begin
      chk("men_in_reset", 64'(men), 64'd0);
      bcnt = 0; wcnt = 0; rcnt = 0; dprev = 1'b0;
    end else begin
      chk("en_vs_busy", 64'(en), 64'(busy));
      chk("bm_ones", bm, '1);
      if (busy) bcnt++;
      if (men) begin
        if (wen) wcnt++;
        if (ren) rcnt++;
        if (op_q.size() == 0) chk("op_unexpected", 64'd1, 64'd0);
        else begin
          o = op_q.pop_front();
          chk("op_wen", 64'(wen), 64'(o.wr));
          chk("op_ren", 64'(ren), 64'(!o.wr));
          chk("op_addr", 64'(addr), 64'(o.addr));
          if (o.wr) chk("op_din", din, o.data);
        end
      end
      if (done && !dprev) begin
        if (res_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          r = res_q.pop_front();
          chk("res_fail", 64'(fail), 64'(r.fail));
          chk("res_fail_addr", 64'(fail_addr), 64'(r.addr));
          chk("res_fail_elem", 64'(fail_elem), 64'(r.elem));
          chk("res_busy_cycles", 64'(bcnt), 64'(r.busy));
          chk("res_writes", 64'(wcnt), 64'(r.nw));
          chk("res_reads", 64'(rcnt), 64'(r.nr));
          chk("res_ops_left", 64'(op_q.size()), 64'd0);
        end
        bcnt = 0; wcnt = 0; rcnt = 0;
      end
      dprev = done;
    end
  end

  // Monitor for the 64-word instance.
  int bcnt64 = 0, oc64 = 0;
  logic dprev64 = 1'b0;
  initial forever begin
    op_t o;
    res_t r;
    @(negedge clk);
    if (!rst_ni) begin
      bcnt64 = 0; oc64 = 0; dprev64 = 1'b0;
    end else begin
      if (busy64) bcnt64++;
      if (men64) begin
        if (oc64 == 5 * N1) chk("e3_start_addr64", 64'(addr64), 64'd63);
        oc64++;
        if (op_q64.size() == 0) chk("op64_unexpected", 64'd1, 64'd0);
        else begin
          o = op_q64.pop_front();
          chk("op64_wen", 64'(wen64), 64'(o.wr));
          chk("op64_addr", 64'(addr64), 64'(o.addr));
          if (o.wr) chk("op64_din", din64, o.data);
        end
      end
      if (done64 && !dprev64) begin
        if (res_q64.size() == 0) chk("done64_unexpected", 64'd1, 64'd0);
        else begin
          r = res_q64.pop_front();
          chk("res64_fail", 64'(fail64), 64'(r.fail));
          chk("res64_busy_cycles", 64'(bcnt64), 64'(r.busy));
          chk("res64_ops_left", 64'(op_q64.size()), 64'd0);
        end
        bcnt64 = 0; oc64 = 0;
      end
      dprev64 = done64;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_fail_addr", 64'(fail_addr), 64'd0);
    chk("rst_fail_elem", 64'(fail_elem), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_men_wen_ren", 64'({men, wen, ren}), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_din", din, 64'd0);
    chk("rst_bm", bm, '1);
  endtask

  // One run of the 256-word instance; optional ignored start pulses or mid-run reset.
  task automatic run0(input bit pulses, input int abort_at);
    bit seen;
    ref_run(N0, 1'b0);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    chk("start_clears_done", 64'(done), 64'd0);
    chk("start_clears_fail", 64'(fail), 64'd0);
    chk("start_sets_busy", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int c = 1; c < 10 * N0 + 40 && !seen; c++) begin
      if (abort_at != 0 && c == abort_at) begin
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs();
        op_q.delete();
        res_q.delete();
        @(negedge clk);
        #2 rst_ni = 1'b1;
        return;
      end
      if (pulses && (c == 10 || c == 500)) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      seen = done;
    end
    if (!seen) chk("timeout_done", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    run0(1'b1, 0);
    st_en = 1'b1; st_addr = 5; st_bit = 3; st_val = 1'b1;
    run0(1'b0, 0);
    st_en = 1'b0; dr_en = 1'b1; dr_addr = 200;
    run0(1'b0, 0);
    dr_en = 1'b0;
    run0(1'b0, 1300);
    run0(1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      st_en = 1'($urandom_range(0, 1));
      dr_en = !st_en;
      st_addr = $urandom_range(0, N0 - 1);
      st_bit = $urandom_range(0, DW - 1);
      st_val = 1'($urandom_range(0, 1));
      dr_addr = $urandom_range(0, N0 - 1);
      run0(1'b0, 0);
    end
    st_en = 1'b0; dr_en = 1'b0;

    ref_run(N1, 1'b1);
    @(negedge clk); start64 = 1'b1;
    @(negedge clk); start64 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 * N1 + 40 && !seen; c++) begin
      @(negedge clk);
      seen = done64;
    end
    if (!seen) chk("timeout_done64", 64'(done64), 64'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
